// File: rtl/pwm_irq_arbiter_pkg.sv
// pwm_irq_arbiter_pkg: shared PWM interrupt types and widths
// Provides the PWM channel count, the matching interrupt ID width and the
// interrupt serialiser FSM state type.
package pwm_irq_arbiter_pkg;

    localparam int PWM_WIDTH = 8;
    localparam int IRQ_ID_W  = $clog2(PWM_WIDTH);

    typedef enum logic [1:0] {IDLE, SERVE, WAIT_REL} irq_state_t;

endpackage

// File: rtl/pwm_irq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate and priority-encode)
// Ports:
//   req   [N-1:0]    request vector
//   ptr   [ID_W-1:0] index with highest priority, must be < N
//   valid            any request set
//   id    [ID_W-1:0] first set request at or after ptr, wrapping N-1 -> 0
module rr_pick #(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scanning from the farthest offset down lets the nearest hit overwrite.
    always_comb begin
        int j;
        valid = 1'b0;
        id    = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= N) ? j - N : j;
            if (req[j]) begin
                valid = 1'b1;
                id    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/pwm_irq_arbiter.sv
// pwm_irq_arbiter: latches PWM events as interrupts and serialises them round-robin
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   src_in   [N_SRC-1:0] PWM event lines, rising edge is an event
//   enable   [N_SRC-1:0] per-source enable mask
//   irq_ack              CPU acknowledge
//   ovf_clr              clears all overflow flags
//   irq_out              interrupt request to CPU
//   irq_id   [ID_W-1:0]  source being served, valid while irq_out=1
//   pending  [N_SRC-1:0] unmasked pending flags
//   overflow [N_SRC-1:0] sticky: event arrived while already pending
//   busy                 FSM not idle
module pwm_irq_arbiter
    import pwm_irq_arbiter_pkg::*;
#(
    parameter int N_SRC = PWM_WIDTH,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    input  logic [N_SRC-1:0] enable,
    input  logic             irq_ack,
    input  logic             ovf_clr,
    output logic             irq_out,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overflow,
    output logic             busy
);

    irq_state_t       state, state_n;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] evt;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] elig;
    logic [ID_W-1:0]  rr_ptr;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;

    assign evt  = src_in & ~src_q;
    assign elig = pending & enable;

    rr_pick #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .valid (gnt_valid),
        .id    (gnt_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // WAIT_REL holds off the next grant until ack drops, so a long ack
    // cannot clear a second source.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = gnt_valid ? SERVE : IDLE;
            SERVE:    state_n = irq_ack ? WAIT_REL : SERVE;
            WAIT_REL: state_n = irq_ack ? WAIT_REL : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        clr     = '0;
        irq_out = (state == SERVE);
        busy    = (state != IDLE);
        if (state == SERVE && irq_ack) clr[irq_id] = 1'b1;
    end

    // A new event beats a simultaneous clear and is not counted as overflow,
    // since the old occurrence is being retired in that very cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q    <= '0;
            pending  <= '0;
            overflow <= '0;
            rr_ptr   <= '0;
            irq_id   <= '0;
        end else begin
            src_q    <= src_in;
            pending  <= (pending & ~clr) | evt;
            overflow <= (ovf_clr ? '0 : overflow) | (evt & pending & ~clr);
            if (state == IDLE && gnt_valid) irq_id <= gnt_id;
            if (state == SERVE && irq_ack)
                rr_ptr <= (irq_id == ID_W'(N_SRC - 1)) ? '0 : irq_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_irq_arbiter.sv
// tb_pwm_irq_arbiter: directed and randomized checks of pwm_irq_arbiter
module tb_pwm_irq_arbiter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] src_in = '0;
    logic [7:0] enable = '0;
    logic       irq_ack = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       irq_out;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] overflow;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: mode 0 idle, 1 serving m_id, 2 waiting for ack release.
    logic [7:0] m_pend, m_ovf, m_srcq;
    int         m_mode, m_id, m_rr;

    pwm_irq_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .src_in   (src_in),
        .enable   (enable),
        .irq_ack  (irq_ack),
        .ovf_clr  (ovf_clr),
        .irq_out  (irq_out),
        .irq_id   (irq_id),
        .pending  (pending),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [7:0] e, int p);
        for (int k = 0; k < N; k++)
            if (e[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_clear();
        m_pend = '0; m_ovf = '0; m_srcq = '0;
        m_mode = 0; m_id = 0; m_rr = 0;
    endtask

    task automatic tick();
        logic [7:0] evt, clr, np, nov;
        int nmode, nid, nrr, g;
        evt = src_in & ~m_srcq;
        clr = '0;
        if (m_mode == 1 && irq_ack) clr[m_id] = 1'b1;
        np  = (m_pend & ~clr) | evt;
        nov = (ovf_clr ? 8'h00 : m_ovf) | (evt & m_pend & ~clr);
        nmode = m_mode; nid = m_id; nrr = m_rr;
        g = pick(m_pend & enable, m_rr);
        if (m_mode == 0 && g >= 0) begin nmode = 1; nid = g; end
        else if (m_mode == 1 && irq_ack) begin nmode = 2; nrr = (m_id + 1) % N; end
        else if (m_mode == 2 && !irq_ack) nmode = 0;
        @(posedge clk);
        #1;
        m_pend = np; m_ovf = nov; m_srcq = src_in;
        m_mode = nmode; m_id = nid; m_rr = nrr;
    endtask

    task automatic do_reset();
        reset = 1'b1; src_in = '0; irq_ack = 1'b0; ovf_clr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL reset_irq_out: got %0b want 0", irq_out); end
        n_cmp++; if (irq_id !== 3'd0) begin n_bad++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending: got %h want 00", pending); end
        n_cmp++; if (overflow !== 8'h00) begin n_bad++; $display("FAIL reset_overflow: got %h want 00", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_single();
        do_reset();
        enable = 8'hFF;
        src_in = 8'h08; tick();
        n_cmp++; if (pending !== 8'h08 || irq_out !== 1'b0) begin n_bad++; $display("FAIL single_latch: got pend=%h irq=%0b want pend=08 irq=0", pending, irq_out); end
        src_in = 8'h00; tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd3 || busy !== 1'b1) begin n_bad++; $display("FAIL single_grant: got irq=%0b id=%0d busy=%0b want 1/3/1", irq_out, irq_id, busy); end
        irq_ack = 1'b1; tick();
        n_cmp++; if (irq_out !== 1'b0 || pending !== 8'h00 || busy !== 1'b1) begin n_bad++; $display("FAIL single_ack: got irq=%0b pend=%h busy=%0b want 0/00/1", irq_out, pending, busy); end
        irq_ack = 1'b0; tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy=%0b want 0", busy); end
        // Pointer now 4: of sources 3 and 5, 5 must win.
        src_in = 8'h28; tick();
        src_in = 8'h00; tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd5) begin n_bad++; $display("FAIL single_ptr: got irq=%0b id=%0d want 1/5", irq_out, irq_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick(); tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd3) begin n_bad++; $display("FAIL single_ptr2: got irq=%0b id=%0d want 1/3", irq_out, irq_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        enable = 8'hFF;
        src_in = 8'hFF; tick();
        src_in = 8'h00; tick();
        for (int g = 0; g < N; g++) begin
            n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'(g)) begin n_bad++; $display("FAIL rr_order: got irq=%0b id=%0d want 1/%0d", irq_out, irq_id, g); end
            irq_ack = 1'b1; tick();
            irq_ack = 1'b0; tick();
            tick();
        end
        n_cmp++; if (irq_out !== 1'b0 || pending !== 8'h00) begin n_bad++; $display("FAIL rr_done: got irq=%0b pend=%h want 0/00", irq_out, pending); end
    endtask

    task automatic test_rotation();
        do_reset();
        enable = 8'hFF;
        src_in = 8'h10; tick(); src_in = 8'h00; tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
        src_in = 8'h44; tick(); src_in = 8'h00; tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd6) begin n_bad++; $display("FAIL rot_first: got irq=%0b id=%0d want 1/6", irq_out, irq_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick(); tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd2) begin n_bad++; $display("FAIL rot_second: got irq=%0b id=%0d want 1/2", irq_out, irq_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    endtask

    task automatic test_mask();
        do_reset();
        enable = 8'hFE;
        src_in = 8'h01; tick(); src_in = 8'h00; tick(); tick();
        n_cmp++; if (irq_out !== 1'b0 || busy !== 1'b0 || pending !== 8'h01) begin n_bad++; $display("FAIL mask_hold: got irq=%0b busy=%0b pend=%h want 0/0/01", irq_out, busy, pending); end
        enable = 8'hFF; tick(); tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd0) begin n_bad++; $display("FAIL mask_release: got irq=%0b id=%0d want 1/0", irq_out, irq_id); end
        enable = 8'h00; tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd0) begin n_bad++; $display("FAIL mask_no_revoke: got irq=%0b id=%0d want 1/0", irq_out, irq_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
        enable = 8'hFF;
    endtask

    task automatic test_overflow();
        do_reset();
        enable = 8'hFF;
        src_in = 8'h02; tick(); src_in = 8'h00; tick();
        n_cmp++; if (overflow !== 8'h00) begin n_bad++; $display("FAIL ovf_none: got %h want 00", overflow); end
        src_in = 8'h02; tick(); src_in = 8'h00; tick();
        n_cmp++; if (overflow !== 8'h02) begin n_bad++; $display("FAIL ovf_set: got %h want 02", overflow); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_cmp++; if (overflow !== 8'h00) begin n_bad++; $display("FAIL ovf_clr: got %h want 00", overflow); end
        // Clear with a simultaneous second event keeps the new overflow.
        ovf_clr = 1'b1; src_in = 8'h02; tick(); ovf_clr = 1'b0; src_in = 8'h00;
        n_cmp++; if (overflow !== 8'h02) begin n_bad++; $display("FAIL ovf_clr_race: got %h want 02", overflow); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    endtask

    task automatic test_collision();
        do_reset();
        enable = 8'hFF;
        src_in = 8'h04; tick(); src_in = 8'h00; tick();
        irq_ack = 1'b1; src_in = 8'h04; tick();
        n_cmp++; if (pending !== 8'h04 || overflow !== 8'h00 || irq_out !== 1'b0) begin n_bad++; $display("FAIL coll_keep: got pend=%h ovf=%h irq=%0b want 04/00/0", pending, overflow, irq_out); end
        irq_ack = 1'b0; src_in = 8'h00; tick(); tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd2) begin n_bad++; $display("FAIL coll_regrant: got irq=%0b id=%0d want 1/2", irq_out, irq_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    endtask

    task automatic test_long_ack();
        int seen;
        do_reset();
        enable = 8'hFF;
        src_in = 8'h0A; tick(); src_in = 8'h00; tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd1) begin n_bad++; $display("FAIL long_first: got irq=%0b id=%0d want 1/1", irq_out, irq_id); end
        irq_ack = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (irq_out) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL long_no_grant: got %0d grant cycles want 0", seen); end
        n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL long_one_clear: got %h want 08", pending); end
        irq_ack = 1'b0; tick();
        n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL long_gap: got %0b want 0", irq_out); end
        tick();
        n_cmp++; if (irq_out !== 1'b1 || irq_id !== 3'd3) begin n_bad++; $display("FAIL long_second: got irq=%0b id=%0d want 1/3", irq_out, irq_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    endtask

    task automatic test_reset_mid_serve();
        do_reset();
        enable = 8'hFF;
        src_in = 8'h21; tick(); src_in = 8'h00; tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (irq_out !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL async_reset: got irq=%0b busy=%0b want 0/0", irq_out, busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        tick();
        n_cmp++; if (pending !== 8'h00 || overflow !== 8'h00 || irq_out !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got pend=%h ovf=%h irq=%0b want 00/00/0", pending, overflow, irq_out); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            src_in  = 8'($urandom) & 8'($urandom);
            enable  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            irq_ack = ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++; if (irq_out !== (m_mode == 1) || busy !== (m_mode != 0)) begin n_bad++; $display("FAIL rand_ctl c=%0d: got irq=%0b busy=%0b want mode %0d", c, irq_out, busy, m_mode); end
            n_cmp++; if (pending !== m_pend || overflow !== m_ovf) begin n_bad++; $display("FAIL rand_flags c=%0d: got pend=%h ovf=%h want %h/%h", c, pending, overflow, m_pend, m_ovf); end
            if (m_mode == 1) begin
                n_cmp++; if (irq_id !== 3'(m_id)) begin n_bad++; $display("FAIL rand_id c=%0d: got %0d want %0d", c, irq_id, m_id); end
            end
        end
        irq_ack = 1'b0; ovf_clr = 1'b0; src_in = '0; enable = 8'hFF;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_round_robin();
        test_rotation();
        test_mask();
        test_overflow();
        test_collision();
        test_long_ack();
        test_reset_mid_serve();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_irq_arbiter.md
Name: pwm_irq_arbiter

Overview:
- Collects per-channel PWM event lines, latches them as pending interrupts, and filters them through a per-source enable mask.
- Serialises pending interrupts to the CPU as a single irq line plus a source ID, with a request/acknowledge handshake.
- Uses round-robin arbitration so no PWM channel can starve another.
- Sits between the PWM channel array and the PS interrupt input; enable mask, overflow clear and status come from the AXI register bank.

Parameters:
- N_SRC, 8 (= `PWM_WIDTH), number of interrupt sources.
- ID_W, $clog2(N_SRC), width of the source ID.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- src_in  input  N_SRC  PWM event lines; rising edge = event.
- enable  input  N_SRC  per-source enable mask from register bank.
- irq_ack  input  1  CPU acknowledge, one or more cycles high.
- ovf_clr  input  1  clears the overflow flags (pulse).
- irq_out  output  1  interrupt request to CPU.
- irq_id  output  ID_W  index of the source being served; valid while irq_out=1.
- pending  output  N_SRC  pending flags (status readback, unmasked).
- overflow  output  N_SRC  sticky: event arrived while already pending.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: clk is `clk`; reset is `reset`, asynchronous, active-high.
  - src_q=0, pending=0, overflow=0, rr_ptr=0.
  - State=IDLE, irq_out=0, irq_id=0, busy=0.
  - Reset mid-SERVE drops irq_out immediately (asynchronous) and loses all pending events.
- Edge detect:
  - src_q <= src_in every clock.
  - evt = src_in & ~src_q.
  - A level held high produces exactly one event.
- Pending latch, per bit i on each clock:
  - If evt[i]=1: pending[i] <= 1. If pending[i] was already 1, also overflow[i] <= 1.
  - Else if clr[i]=1: pending[i] <= 0.
  - Event wins over a simultaneous clear: pending stays 1 and overflow is not set.
- Eligibility:
  - elig = pending & enable.
  - Masked events are still latched into pending; they become eligible once enabled.
- Round-robin pick (combinational):
  - Selects the first set bit of elig, searching from rr_ptr upward and wrapping N_SRC-1 -> 0.
  - Outputs gnt_valid and gnt_id.
- FSM, type irq_state_t:
  - IDLE: if gnt_valid, register irq_id <= gnt_id and go to SERVE. Otherwise stay.
  - SERVE: irq_out=1 and irq_id is held stable. On irq_ack=1: clr[irq_id]=1 for one cycle, rr_ptr <= (irq_id+1) mod N_SRC, go to WAIT_REL.
  - WAIT_REL: irq_out=0. Stay while irq_ack=1; go to IDLE when irq_ack=0. This prevents a long ack from clearing the next grant.
- Output decoding:
  - irq_out = (state==SERVE), decoded directly from the state register (no combinational path from inputs).
  - busy = (state!=IDLE).
- Latency:
  - src_in rises before edge k -> pending set at k -> irq_out=1 after edge k+1.
  - Ack sampled at edge m -> irq_out=0 after m.
  - Minimum gap between grants is 2 cycles (WAIT_REL + IDLE).
- Disabling the served source during SERVE does not revoke the grant; the handshake completes normally.
- irq_ack in IDLE or WAIT_REL is ignored.
- ovf_clr clears all overflow bits. An event in the same cycle that would set overflow[i] wins.
- N_SRC must be >= 2. rr_ptr wraps modulo N_SRC, including for non-power-of-2 values.

Decomposition:
- PKG_pwm gains:
  - typedef enum logic [1:0] {IDLE, SERVE, WAIT_REL} irq_state_t;
  - localparam IRQ_ID_W = $clog2(`PWM_WIDTH).
- Sub-module rr_pick (parameter N; inputs req[N] and ptr; outputs valid and id): purely combinational rotate-and-priority-encode, reusable by other arbiters.

Test Plan:
- Single source: src_in[3] rises, enable=8'hFF -> irq_out=1 two cycles later with irq_id=3. Ack 1 cycle -> irq_out=0, pending=0, rr_ptr=4.
- Round-robin: all 8 sources pulse in the same cycle, ack each grant immediately -> served order 0,1,...,7, one grant every 3 cycles, pending=0 at the end.
- Rotation: rr_ptr=5 and sources 2 and 6 pending -> grant order 6 then 2.
- Mask: enable=8'hFE, pulse src 0 -> no irq, pending[0]=1. Then set enable[0]=1 -> irq with irq_id=0 two cycles later.
- Overflow and collision:
  - Two pulses on src 1 before ack -> overflow[1]=1; ovf_clr -> overflow=0.
  - New src 2 event in the same cycle as the ack of id 2 -> pending[2] stays 1 and a second grant of id 2 follows.
- Reset and long ack:
  - Assert reset during SERVE -> irq_out=0 immediately; all flags are 0 after release.
  - Hold irq_ack high for 10 cycles with 2 sources pending -> exactly one clear; the second grant appears only after ack drops.
